image_stream_source: RTL and testbench

//   Pixel transmitter for the feature-extraction pipeline: the sending end of its start/pixel_valid/pixel_in stream.
//   A host loads one IMG_WIDTH x IMG_HEIGHT 8-bit frame into a local buffer through a write port.
//   On go, the block issues the start pulse, then streams the frame in raster order with optional inter-row gaps.
//   It then waits for the extractor's done pulse and reports frame completion or timeout.

---
 rtl/image_stream_source.sv | 175 +++++++++++++++++
 tb/tb_image_stream_source.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/image_stream_source.sv
// image_stream_source
//   Holds one IMG_WIDTH x IMG_HEIGHT 8-bit frame loaded by a host and sends it
//   to the feature extractor on request. The block pulses start_signal, streams
//   the pixels in raster order (with optional idle gaps between rows), then waits
//   for done_in and reports either frame_done or a sticky timeout_err.
// Ports
//   clk, rst          clock; synchronous active-high reset
//   wr_en/addr/data   host buffer write port (accepted only while idle)
//   go                frame request, sampled each cycle while idle
//   done_in           frame-complete pulse from the extractor
//   start_signal      one-cycle start-of-frame pulse
//   pixel_valid_out   pixel_out carries a pixel this cycle
//   pixel_out         pixel data, held while not valid
//   busy              high from accepted go until back in idle
//   frame_done        one-cycle pulse: done_in received
//   timeout_err       sticky: no done_in in time; cleared by the next accepted go
module image_stream_source #(
  parameter int IMG_WIDTH      = 32,
  parameter int IMG_HEIGHT     = 32,
  parameter int GAP_CYCLES     = 0,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int ADDR_W         = $clog2(IMG_WIDTH*IMG_HEIGHT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_data,
  input  logic              go,
  input  logic              done_in,
  output logic              start_signal,
  output logic              pixel_valid_out,
  output logic [7:0]        pixel_out,
  output logic              busy,
  output logic              frame_done,
  output logic              timeout_err
);

  localparam int NPIX  = IMG_WIDTH*IMG_HEIGHT;
  localparam int CNT_W = ADDR_W + 1;
  localparam int COL_W = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES+1) : 1;
  localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES+1) : 1;

  localparam logic [CNT_W-1:0] NPIX_C   = CNT_W'(NPIX);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH-1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES-1 : 0);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES-1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_STREAM, S_GAP, S_WAIT} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;     // index of the next pixel to read
  logic [COL_W-1:0] col_q, col_d;     // column of the next pixel to read
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [TMO_W-1:0] wcnt_q, wcnt_d;
  logic             valid_q;
  logic [7:0]       pix_q;
  logic             done_q, done_d;
  logic             tmo_q, tmo_d;
  logic             issue;            // read a pixel this cycle; it is shown next cycle
  logic             addr_ok;
  logic             wr_ok;

  logic [7:0] mem [NPIX];

  generate
    if (NPIX == (1 << ADDR_W)) begin : g_full
      assign addr_ok = 1'b1;
    end else begin : g_part
      assign addr_ok = ({1'b0, wr_addr} < NPIX_C);
    end
  endgenerate

  assign wr_ok = wr_en && (state_q == S_IDLE) && addr_ok;

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_addr] <= wr_data;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    col_d   = col_q;
    gap_d   = gap_q;
    wcnt_d  = wcnt_q;
    done_d  = 1'b0;
    tmo_d   = tmo_q;
    issue   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (go) begin
          state_d = S_START;
          cnt_d   = '0;
          col_d   = '0;
          gap_d   = '0;
          wcnt_d  = '0;
          tmo_d   = 1'b0;
        end
      end
      S_START: begin
        issue   = 1'b1;
        state_d = S_STREAM;
      end
      S_STREAM: begin
        // The pixel visible now was read last cycle; col_q == 0 means it closed a row.
        if (cnt_q == NPIX_C) begin
          state_d = S_WAIT;
        end else if ((GAP_CYCLES > 0) && (col_q == '0)) begin
          state_d = S_GAP;
          gap_d   = '0;
        end else begin
          issue = 1'b1;
        end
      end
      S_GAP: begin
        // Read on the final gap cycle so the next pixel lands right after the gap.
        if (gap_q == GAP_LAST) begin
          issue   = 1'b1;
          state_d = S_STREAM;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      S_WAIT: begin
        if (done_in) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else if (wcnt_q == TMO_LAST) begin
          tmo_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          wcnt_d = wcnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (issue) begin
      cnt_d = cnt_q + 1'b1;
      col_d = (col_q == COL_LAST) ? '0 : col_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      col_q   <= '0;
      gap_q   <= '0;
      wcnt_q  <= '0;
      valid_q <= 1'b0;
      pix_q   <= '0;
      done_q  <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      col_q   <= col_d;
      gap_q   <= gap_d;
      wcnt_q  <= wcnt_d;
      valid_q <= issue;
      done_q  <= done_d;
      tmo_q   <= tmo_d;
      if (issue) pix_q <= mem[cnt_q[ADDR_W-1:0]];
    end
  end

  assign start_signal    = (state_q == S_START);
  assign busy            = (state_q != S_IDLE);
  assign pixel_valid_out = valid_q;
  assign pixel_out       = pix_q;
  assign frame_done      = done_q;
  assign timeout_err     = tmo_q;

endmodule

// File: tb/tb_image_stream_source.sv
module tb_image_stream_source;

  localparam int W   = 32;
  localparam int H   = 32;
  localparam int GAP = 3;
  localparam int TMO = 16;
  localparam int N   = W*H;
  localparam int AW  = 10;
  localparam int BIG = 1 << 30;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [7:0]    wr_data = '0;
  logic          go = 1'b0;
  logic          done_in = 1'b0;
  logic          start_signal, pixel_valid_out, busy, frame_done, timeout_err;
  logic [7:0]    pixel_out;

  image_stream_source #(
    .IMG_WIDTH(W), .IMG_HEIGHT(H), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .go(go), .done_in(done_in), .start_signal(start_signal),
    .pixel_valid_out(pixel_valid_out), .pixel_out(pixel_out), .busy(busy),
    .frame_done(frame_done), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [7:0] data; int at; } pix_t;
  pix_t pix_q[$];
  int   start_q[$];
  int   done_q[$];

  int nerr = 0;
  int nchk = 0;
  int busy_from = BIG, busy_to = 0;
  int te_rise = BIG, te_clr = BIG;
  logic [7:0] ref_buf [N];
  logic [7:0] last_exp = '0;
  bit mon_en = 1'b0;

  function automatic void check(string name, int act, int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Monitor: compares DUT outputs against the scoreboard queues and level models.
  always @(negedge clk) begin
    if (mon_en) begin
      pix_t p;
      check("busy", int'(busy), int'(cyc >= busy_from && cyc < busy_to));
      check("timeout_err", int'(timeout_err), int'(cyc >= te_rise && cyc < te_clr));
      if (start_signal) begin
        if (start_q.size() == 0) check("start_spurious", int'(start_signal), 0);
        else check("start_cycle", cyc, start_q.pop_front());
      end else if (start_q.size() > 0 && start_q[0] <= cyc) begin
        check("start_missing", int'(start_signal), 1);
        void'(start_q.pop_front());
      end
      if (frame_done) begin
        if (done_q.size() == 0) check("frame_done_spurious", int'(frame_done), 0);
        else check("frame_done_cycle", cyc, done_q.pop_front());
      end else if (done_q.size() > 0 && done_q[0] <= cyc) begin
        check("frame_done_missing", int'(frame_done), 1);
        void'(done_q.pop_front());
      end
      if (pixel_valid_out) begin
        if (pix_q.size() == 0) check("valid_spurious", int'(pixel_valid_out), 0);
        else begin
          p = pix_q.pop_front();
          check("pixel_cycle", cyc, p.at);
          check("pixel_data", int'(pixel_out), int'(p.data));
          last_exp = p.data;
        end
      end else begin
        check("pixel_hold", int'(pixel_out), int'(last_exp));
        if (pix_q.size() > 0 && pix_q[0].at <= cyc) begin
          check("valid_missing", int'(pixel_valid_out), 1);
          void'(pix_q.pop_front());
        end
      end
      if (rst) last_exp = '0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Loads buf[0..N-2]; address N-1 is written together with go in run_frame.
  task automatic load(bit ramp);
    for (int k = 0; k < N-1; k++) begin
      wr_en   = 1'b1;
      wr_addr = AW'(k);
      wr_data = ramp ? 8'(k) : 8'($urandom);
      ref_buf[k] = wr_data;
      tick();
    end
    wr_en = 1'b0;
  endtask

  // One frame. done_d in 1..TMO: done_in pulsed done_d cycles after the last pixel;
  // otherwise no done_in. rst_pix >= 0 asserts reset while that pixel is shown.
  task automatic run_frame(int done_d, int rst_pix, bit last_wr, logic [7:0] wd);
    int T, L, P, end_c, s_done, s_go, s_wr, hi;
    bit ok_done;
    ok_done = (done_d >= 1 && done_d <= TMO && rst_pix < 0);
    go = 1'b1;
    T  = cyc;
    if (last_wr) begin
      wr_en = 1'b1; wr_addr = AW'(N-1); wr_data = wd;
      ref_buf[N-1] = wd;
    end
    start_q.push_back(T+1);
    busy_from = T+1;
    busy_to   = BIG;
    if (te_clr > T+1) te_clr = T+1;
    for (int k = 0; k < N; k++) pix_q.push_back('{ref_buf[k], T+2+k+GAP*(k/W)});
    L = T+1+N+GAP*(H-1);
    P = (rst_pix >= 0) ? T+2+rst_pix+GAP*(rst_pix/W) : BIG;
    hi = (P-1 < L) ? P-1 : L;
    s_done = int'($urandom_range(hi, T+2));
    s_go   = int'($urandom_range(hi, T+2));
    s_wr   = int'($urandom_range(hi, T+2));
    if (ok_done) begin
      done_q.push_back(L+done_d+1);
      busy_to = L+done_d+1;
    end else if (rst_pix < 0) begin
      te_rise = L+TMO+1;
      te_clr  = BIG;
      busy_to = L+TMO+1;
    end
    end_c = (rst_pix >= 0) ? P+3 : busy_to+2;
    tick();
    go = 1'b0;
    wr_en = 1'b0;
    while (cyc < end_c) begin
      go      = (cyc == s_go);
      done_in = (cyc == s_done) || (ok_done && cyc == L+done_d);
      wr_en   = (cyc == s_wr);
      if (wr_en) begin
        wr_addr = AW'($urandom);
        wr_data = 8'($urandom);
      end
      rst = (cyc == P) || (cyc == P+1);
      if (cyc == P) begin
        while (pix_q.size() > 0 && pix_q[$].at > P) void'(pix_q.pop_back());
        busy_to = P+1;
        if (te_clr > P+1) te_clr = P+1;
      end
      tick();
    end
    go = 1'b0; done_in = 1'b0; wr_en = 1'b0; rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    tick();
    mon_en = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    load(1'b1);
    run_frame(10, -1, 1'b1, 8'(N-1));
    run_frame(0, -1, 1'b0, '0);
    load(1'b0);
    run_frame(int'($urandom_range(TMO, 1)), -1, 1'b1, 8'($urandom));
    run_frame(5, 500, 1'b0, '0);
    run_frame(int'($urandom_range(TMO, 1)), -1, 1'b0, '0);
    run_frame(TMO, -1, 1'b0, '0);
    run_frame(1, -1, 1'b0, '0);
    repeat (4) tick();
    check("pixels_left", pix_q.size(), 0);
    check("starts_left", start_q.size(), 0);
    check("dones_left", done_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

endmodule
